// File: rtl/stack_up_tx_pkg.sv
// Shared definitions for the upstream transmitter and its manager-side peer:
// framing codes, framer state encoding and default widths.
package stack_up_tx_pkg;

  localparam int DATA_W_DEF  = 64;
  localparam int OOB_W_DEF   = 32;
  localparam int TYPE_W_DEF  = 2;
  localparam int DEPTH_DEF   = 8;
  localparam int MAX_PKT_DEF = 256;

  typedef enum logic [1:0] {
    CNTL_SOM_EOM = 2'b00,
    CNTL_SOM     = 2'b01,
    CNTL_MOM     = 2'b10,
    CNTL_EOM     = 2'b11
  } cntl_e;

  // state     | meaning
  // ST_IDLE   | next loaded word starts a packet
  // ST_IN_PKT | a packet is open; next word is MOM or EOM
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } frame_state_e;

endpackage

// File: rtl/stack_up_tx_fifo.sv
// Register-array FIFO with a registered occupancy count and a
// combinational head read. DEPTH must be a power of two, at least 2,
// so the pointers wrap naturally.
module stack_up_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_poweron,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count as is.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/stack_up_tx.sv
// Upstream transmitter: buffers source words, frames them into packets
// (SOM/MOM/EOM), and presents them through a registered output stage.
// A word arriving while the FIFO is empty and the output stage is free
// bypasses the FIFO so it is visible one cycle after it is pushed.
module stack_up_tx
  import stack_up_tx_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OOB_W   = OOB_W_DEF,
  parameter int TYPE_W  = TYPE_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int MAX_PKT = MAX_PKT_DEF
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              src__stu__valid,
  output logic              stu__src__ready,
  input  logic [TYPE_W-1:0] src__stu__type,
  input  logic [DATA_W-1:0] src__stu__data,
  input  logic [OOB_W-1:0]  src__stu__oob_data,
  input  logic              src__stu__last,
  output logic              stu__mgr__valid,
  output logic [1:0]        stu__mgr__cntl,
  input  logic              mgr__stu__ready,
  output logic [TYPE_W-1:0] stu__mgr__type,
  output logic [DATA_W-1:0] stu__mgr__data,
  output logic [OOB_W-1:0]  stu__mgr__oob_data,
  output logic              stu__sys__idle,
  output logic              stu__sys__pkt_err
);

  localparam int ENTRY_W = TYPE_W + DATA_W + OOB_W + 1;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int CNT_W   = $clog2(MAX_PKT) + 1;

  logic [ENTRY_W-1:0] src_entry;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;

  logic src_push;
  logic out_free;
  logic load_fifo;
  logic load_bypass;
  logic load;
  logic fifo_push;

  logic [TYPE_W-1:0] ld_type;
  logic [DATA_W-1:0] ld_data;
  logic [OOB_W-1:0]  ld_oob;
  logic              ld_last;

  frame_state_e      state;
  frame_state_e      state_next;
  cntl_e             ld_cntl;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W-1:0]  cnt_inc;
  logic              at_end;
  logic              trunc;

  logic              out_valid;
  cntl_e             out_cntl;
  logic [TYPE_W-1:0] out_type;
  logic [DATA_W-1:0] out_data;
  logic [OOB_W-1:0]  out_oob;
  logic              pkt_err;

  // Source handshake is a function of registered count only.
  assign stu__src__ready = (fifo_count < CW'(DEPTH));
  assign src_push        = src__stu__valid && stu__src__ready;
  assign src_entry       = {src__stu__type, src__stu__data, src__stu__oob_data, src__stu__last};

  assign out_free    = !out_valid || mgr__stu__ready;
  assign load_fifo   = out_free && !fifo_empty;
  assign load_bypass = out_free && fifo_empty && src_push;
  assign load        = load_fifo || load_bypass;
  assign fifo_push   = src_push && !load_bypass;

  assign {ld_type, ld_data, ld_oob, ld_last} = load_fifo ? fifo_head : src_entry;

  stack_up_tx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) fifo_i (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .push          (fifo_push),
    .push_data     (src_entry),
    .pop           (load_fifo),
    .head          (fifo_head),
    .count         (fifo_count),
    .empty         (fifo_empty)
  );

  assign cnt_inc = word_cnt + CNT_W'(1);

  // Framer state and word counter advance on every load into the output stage.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
    end else begin
      state    <= state_next;
      word_cnt <= cnt_next;
    end
  end

  // Framing decision for the word being loaded; a packet reaching MAX_PKT
  // without last is forced closed and flagged.
  always_comb begin
    state_next = state;
    ld_cntl    = CNTL_SOM_EOM;
    cnt_next   = word_cnt;
    trunc      = 1'b0;
    at_end     = ld_last || (cnt_inc == CNT_W'(MAX_PKT));
    if (load) begin
      trunc = at_end && !ld_last;
      case (state)
        ST_IDLE: begin
          if (at_end) begin
            ld_cntl  = CNTL_SOM_EOM;
            cnt_next = '0;
          end else begin
            ld_cntl    = CNTL_SOM;
            state_next = ST_IN_PKT;
            cnt_next   = cnt_inc;
          end
        end
        ST_IN_PKT: begin
          if (at_end) begin
            ld_cntl    = CNTL_EOM;
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            ld_cntl  = CNTL_MOM;
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Output stage: holds its word until accepted; oob only changes on a
  // packet-starting word so it carries the packet tag on every word.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      out_valid <= 1'b0;
      out_cntl  <= CNTL_SOM_EOM;
      out_type  <= '0;
      out_data  <= '0;
      out_oob   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_cntl  <= ld_cntl;
      out_type  <= ld_type;
      out_data  <= ld_data;
      if (state == ST_IDLE) out_oob <= ld_oob;
    end else if (mgr__stu__ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky truncation flag.
  always_ff @(posedge clk) begin
    if (reset_poweron) pkt_err <= 1'b0;
    else if (trunc)    pkt_err <= 1'b1;
  end

  assign stu__mgr__valid    = out_valid;
  assign stu__mgr__cntl     = out_cntl;
  assign stu__mgr__type     = out_type;
  assign stu__mgr__data     = out_data;
  assign stu__mgr__oob_data = out_oob;
  assign stu__sys__pkt_err  = pkt_err;
  assign stu__sys__idle     = fifo_empty && !out_valid && (state == ST_IDLE);

endmodule

// File: tb/tb_stack_up_tx.sv
// Directed and random checks of stack_up_tx: framing, latency, back-pressure,
// truncation at MAX_PKT and mid-packet reset.
module tb_stack_up_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_poweron;
  logic        src_valid, src_ready, src_last;
  logic [1:0]  src_type;
  logic [63:0] src_data;
  logic [31:0] src_oob;
  logic        mgr_valid, mgr_ready;
  logic [1:0]  mgr_cntl, mgr_type;
  logic [63:0] mgr_data;
  logic [31:0] mgr_oob;
  logic        sys_idle, pkt_err;

  logic        t_valid, t_src_ready, t_last;
  logic [1:0]  t_src_type;
  logic [63:0] t_src_data;
  logic [31:0] t_src_oob;
  logic        t_mgr_valid, t_mgr_ready;
  logic [1:0]  t_cntl, t_type;
  logic [63:0] t_data;
  logic [31:0] t_oob;
  logic        t_idle, t_pkt_err;

  int ntests = 0;
  int nfail  = 0;

  stack_up_tx dut (
    .clk(clk), .reset_poweron(reset_poweron),
    .src__stu__valid(src_valid), .stu__src__ready(src_ready),
    .src__stu__type(src_type), .src__stu__data(src_data),
    .src__stu__oob_data(src_oob), .src__stu__last(src_last),
    .stu__mgr__valid(mgr_valid), .stu__mgr__cntl(mgr_cntl),
    .mgr__stu__ready(mgr_ready), .stu__mgr__type(mgr_type),
    .stu__mgr__data(mgr_data), .stu__mgr__oob_data(mgr_oob),
    .stu__sys__idle(sys_idle), .stu__sys__pkt_err(pkt_err)
  );

  stack_up_tx #(.MAX_PKT(4)) dut4 (
    .clk(clk), .reset_poweron(reset_poweron),
    .src__stu__valid(t_valid), .stu__src__ready(t_src_ready),
    .src__stu__type(t_src_type), .src__stu__data(t_src_data),
    .src__stu__oob_data(t_src_oob), .src__stu__last(t_last),
    .stu__mgr__valid(t_mgr_valid), .stu__mgr__cntl(t_cntl),
    .mgr__stu__ready(t_mgr_ready), .stu__mgr__type(t_type),
    .stu__mgr__data(t_data), .stu__mgr__oob_data(t_oob),
    .stu__sys__idle(t_idle), .stu__sys__pkt_err(t_pkt_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_poweron = 1'b1;
    src_valid = 1'b0; src_last = 1'b0; src_type = '0; src_data = '0; src_oob = '0;
    mgr_ready = 1'b0;
    t_valid = 1'b0; t_last = 1'b0; t_src_type = '0; t_src_data = '0; t_src_oob = '0;
    t_mgr_ready = 1'b0;
    tick; tick;
    reset_poweron = 1'b0;
    ntests++; if (mgr_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b want 0", mgr_valid); end
    ntests++; if ({mgr_cntl, mgr_type} !== 4'b0) begin nfail++; $display("FAIL reset_cntl_type: got %b want 0000", {mgr_cntl, mgr_type}); end
    ntests++; if (mgr_data !== 64'h0 || mgr_oob !== 32'h0) begin nfail++; $display("FAIL reset_data_oob: got %h/%h want 0/0", mgr_data, mgr_oob); end
    ntests++; if (src_ready !== 1'b1 || t_src_ready !== 1'b1) begin nfail++; $display("FAIL reset_src_ready: got %b%b want 11", src_ready, t_src_ready); end
    ntests++; if (sys_idle !== 1'b1) begin nfail++; $display("FAIL reset_idle: got %b want 1", sys_idle); end
    ntests++; if (pkt_err !== 1'b0) begin nfail++; $display("FAIL reset_pkt_err: got %b want 0", pkt_err); end
  endtask

  task automatic test_single;
    mgr_ready = 1'b1;
    src_valid = 1'b1; src_data = 64'hA5; src_oob = 32'h11; src_last = 1'b1; src_type = 2'b01;
    tick;
    src_valid = 1'b0;
    ntests++; if (mgr_valid !== 1'b1 || mgr_cntl !== 2'b00) begin nfail++; $display("FAIL single_valid_cntl: got %b/%b want 1/00", mgr_valid, mgr_cntl); end
    ntests++; if (mgr_data !== 64'hA5 || mgr_oob !== 32'h11 || mgr_type !== 2'b01) begin nfail++; $display("FAIL single_word: got %h/%h/%b want a5/11/01", mgr_data, mgr_oob, mgr_type); end
    tick;
    ntests++; if (mgr_valid !== 1'b0 || sys_idle !== 1'b1) begin nfail++; $display("FAIL single_idle: got valid %b idle %b want 0 1", mgr_valid, sys_idle); end
  endtask

  task automatic test_multi;
    logic [1:0] ec [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
    mgr_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      src_valid = 1'b1; src_data = 64'h200 + 64'(w); src_oob = (w == 0) ? 32'd7 : 32'd9;
      src_last = (w == 3); src_type = 2'b10;
      tick;
      src_valid = 1'b0;
      ntests++;
      if (mgr_valid !== 1'b1 || mgr_cntl !== ec[w] || mgr_oob !== 32'd7 || mgr_data !== 64'h200 + 64'(w)) begin
        nfail++; $display("FAIL multi_word%0d: got v%b c%b oob %0d data %h want v1 c%b oob 7 data %h",
                          w, mgr_valid, mgr_cntl, mgr_oob, mgr_data, ec[w], 64'h200 + 64'(w));
      end
    end
    tick;
    ntests++; if (sys_idle !== 1'b1) begin nfail++; $display("FAIL multi_idle: got %b want 1", sys_idle); end
  endtask

  task automatic test_backpressure;
    int i = 0;
    int k = 0;
    int cyc = 0;
    logic acc, xf;
    logic [1:0] ecntl;
    mgr_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      src_valid = (i < 10); src_data = 64'd100 + 64'(i); src_last = (i == 9);
      src_oob = 32'd5; src_type = 2'b00;
      acc = src_valid && src_ready;
      tick;
      if (acc) i++;
      ntests++;
      if (mgr_valid !== 1'b1 || mgr_data !== 64'd100 || mgr_cntl !== 2'b01) begin
        nfail++; $display("FAIL bp_hold c%0d: got v%b data %0d c%b want v1 data 100 c01", c, mgr_valid, mgr_data, mgr_cntl);
      end
    end
    ntests++; if (i != 9 || src_ready !== 1'b0) begin nfail++; $display("FAIL bp_accepted: got %0d words ready %b want 9 ready 0", i, src_ready); end
    mgr_ready = 1'b1;
    while (k < 10 && cyc < 60) begin
      src_valid = (i < 10); src_data = 64'd100 + 64'(i); src_last = (i == 9);
      acc = src_valid && src_ready;
      xf  = mgr_valid && mgr_ready;
      if (xf) begin
        ecntl = (k == 0) ? 2'b01 : ((k == 9) ? 2'b11 : 2'b10);
        ntests++;
        if (mgr_data !== 64'd100 + 64'(k) || mgr_cntl !== ecntl || mgr_oob !== 32'd5) begin
          nfail++; $display("FAIL bp_drain%0d: got data %0d c%b oob %0d want data %0d c%b oob 5",
                            k, mgr_data, mgr_cntl, mgr_oob, 100 + k, ecntl);
        end
      end
      tick;
      if (acc) i++;
      if (xf) k++;
      cyc++;
    end
    src_valid = 1'b0;
    ntests++; if (k != 10) begin nfail++; $display("FAIL bp_delivered: got %0d words want 10", k); end
  endtask

  task automatic test_truncate;
    logic [31:0] soob [6] = '{32'd3, 32'd4, 32'd4, 32'd4, 32'd8, 32'd9};
    logic [31:0] eoob [6] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd8, 32'd8};
    logic [1:0]  ec   [6] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b01, 2'b11};
    logic        perr [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    t_mgr_ready = 1'b1;
    for (int w = 0; w < 6; w++) begin
      t_valid = 1'b1; t_src_data = 64'd300 + 64'(w); t_src_oob = soob[w];
      t_last = (w == 5); t_src_type = 2'b10;
      tick;
      t_valid = 1'b0;
      ntests++;
      if (t_mgr_valid !== 1'b1 || t_cntl !== ec[w] || t_oob !== eoob[w] || t_data !== 64'd300 + 64'(w) || t_type !== 2'b10) begin
        nfail++; $display("FAIL trunc_word%0d: got v%b c%b oob %0d data %0d type %b want v1 c%b oob %0d data %0d type 10",
                          w, t_mgr_valid, t_cntl, t_oob, t_data, t_type, ec[w], eoob[w], 300 + w);
      end
      ntests++;
      if (t_pkt_err !== perr[w]) begin nfail++; $display("FAIL trunc_err%0d: got %b want %b", w, t_pkt_err, perr[w]); end
    end
    tick;
    ntests++; if (t_idle !== 1'b1 || t_pkt_err !== 1'b1) begin nfail++; $display("FAIL trunc_end: got idle %b err %b want 1 1", t_idle, t_pkt_err); end
  endtask

  task automatic test_reset_mid;
    mgr_ready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      src_valid = 1'b1; src_data = 64'd400 + 64'(w); src_oob = 32'h44; src_last = 1'b0;
      tick;
    end
    src_valid = 1'b0;
    reset_poweron = 1'b1;
    tick;
    reset_poweron = 1'b0;
    ntests++; if (mgr_valid !== 1'b0 || sys_idle !== 1'b1) begin nfail++; $display("FAIL rstmid_flush: got valid %b idle %b want 0 1", mgr_valid, sys_idle); end
    ntests++; if (t_pkt_err !== 1'b0) begin nfail++; $display("FAIL rstmid_err_clear: got %b want 0", t_pkt_err); end
    mgr_ready = 1'b1;
    tick;
    ntests++; if (mgr_valid !== 1'b0) begin nfail++; $display("FAIL rstmid_stale: got valid %b want 0", mgr_valid); end
    src_valid = 1'b1; src_data = 64'd500; src_oob = 32'h55; src_last = 1'b0;
    tick;
    ntests++; if (mgr_valid !== 1'b1 || mgr_cntl !== 2'b01 || mgr_data !== 64'd500 || mgr_oob !== 32'h55) begin
      nfail++; $display("FAIL rstmid_som: got v%b c%b data %0d oob %h want v1 c01 data 500 oob 55", mgr_valid, mgr_cntl, mgr_data, mgr_oob);
    end
    src_data = 64'd501; src_oob = 32'h66; src_last = 1'b1;
    tick;
    src_valid = 1'b0;
    ntests++; if (mgr_cntl !== 2'b11 || mgr_data !== 64'd501 || mgr_oob !== 32'h55 || pkt_err !== 1'b0) begin
      nfail++; $display("FAIL rstmid_eom: got c%b data %0d oob %h err %b want c11 data 501 oob 55 err 0", mgr_cntl, mgr_data, mgr_oob, pkt_err);
    end
    tick;
  endtask

  typedef struct packed {
    logic [1:0]  cntl;
    logic [1:0]  typ;
    logic [63:0] data;
    logic [31:0] oob;
  } exp_t;

  task automatic test_random;
    exp_t        q[$];
    exp_t        e;
    exp_t        got;
    int          pkts = 0;
    int          w = 0;
    int          len;
    int          cyc = 0;
    int          bad = 0;
    logic [31:0] poob;
    logic [1:0]  ctype;
    logic [63:0] seq = 64'h1000;
    logic        acc, xf;
    len   = $urandom_range(1, 6);
    poob  = $urandom;
    ctype = 2'($urandom_range(0, 3));
    while ((pkts < 1000 || q.size() > 0) && cyc < 40000) begin
      src_valid = (pkts < 1000) && ($urandom_range(0, 3) != 0);
      src_data  = seq;
      src_type  = ctype;
      src_last  = (w == len - 1);
      src_oob   = (w == 0) ? poob : $urandom;
      mgr_ready = ($urandom_range(0, 3) != 0);
      acc = src_valid && src_ready;
      xf  = mgr_valid && mgr_ready;
      if (xf) begin
        got = '{mgr_cntl, mgr_type, mgr_data, mgr_oob};
        ntests++;
        if (q.size() == 0) begin
          nfail++; $display("FAIL rand_extra: got word %h with nothing expected", mgr_data);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            nfail++; bad++;
            if (bad < 10) $display("FAIL rand_word: got c%b t%b d%h o%h want c%b t%b d%h o%h",
                                   got.cntl, got.typ, got.data, got.oob, e.cntl, e.typ, e.data, e.oob);
          end
        end
      end
      if (acc) begin
        e.cntl = (len == 1) ? 2'b00 : ((w == 0) ? 2'b01 : ((w == len - 1) ? 2'b11 : 2'b10));
        e.typ  = ctype;
        e.data = seq;
        e.oob  = poob;
        q.push_back(e);
        seq++;
        w++;
        if (w == len) begin
          pkts++; w = 0;
          len  = $urandom_range(1, 6);
          poob = $urandom;
        end
        ctype = 2'($urandom_range(0, 3));
      end
      tick;
      cyc++;
    end
    src_valid = 1'b0;
    ntests++; if (pkts != 1000 || q.size() != 0) begin nfail++; $display("FAIL rand_complete: got %0d packets %0d pending want 1000 0", pkts, q.size()); end
    ntests++; if (sys_idle !== 1'b1 || pkt_err !== 1'b0) begin nfail++; $display("FAIL rand_idle: got idle %b err %b want 1 0", sys_idle, pkt_err); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_multi;
    test_backpressure;
    test_truncate;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/stack_up_tx.md
STACK_UP_TX -- requirements
Module: stack_up_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of the upstream data word.
REQ-002 SHALL have parameter OOB_W, default 32, width of the out-of-band tag.
REQ-003 SHALL have parameter TYPE_W, default 2, width of the type field (control/data, vector/scalar).
REQ-004 SHALL have parameter DEPTH, default 8, FIFO entries (power of two).
REQ-005 SHALL have parameter MAX_PKT, default 256, maximum words per packet.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 reset_poweron  input  1  synchronous, active-high reset.
REQ-008 src__stu__valid  input  1  source word valid.
REQ-009 stu__src__ready  output  1  transmitter can accept a word.
REQ-010 src__stu__type  input  TYPE_W  word type.
REQ-011 src__stu__data  input  DATA_W  word payload.
REQ-012 src__stu__oob_data  input  OOB_W  packet tag; meaningful on the first word only.
REQ-013 src__stu__last  input  1  final word of the packet.
REQ-014 stu__mgr__valid  output  1  upstream word valid to manager.
REQ-015 stu__mgr__cntl  output  2  framing: SOM_EOM=00, SOM=01, MOM=10, EOM=11.
REQ-016 mgr__stu__ready  input  1  manager accepts the word.
REQ-017 stu__mgr__type / stu__mgr__data / stu__mgr__oob_data  output  TYPE_W / DATA_W / OOB_W  upstream word fields.
REQ-018 stu__sys__idle  output  1  FIFO empty, no word pending, framer in IDLE.
REQ-019 stu__sys__pkt_err  output  1  sticky: packet truncated at MAX_PKT.

Function
REQ-020 Source push SHALL occur when src__stu__valid && stu__src__ready; stu__src__ready SHALL equal (count < DEPTH) from registered count only, with no combinational path from mgr__stu__ready.
REQ-021 FIFO entry SHALL store {type, data, oob, last}; pointers SHALL wrap modulo DEPTH; count SHALL be unchanged on a simultaneous push and pop.
REQ-022 Upstream transfer SHALL occur when stu__mgr__valid && mgr__stu__ready; an output register stage SHALL hold the head word.
REQ-023 While stu__mgr__valid=1 and mgr__stu__ready=0, all stu__mgr__* outputs SHALL remain stable.
REQ-024 Latency: a word pushed into an empty block at cycle N SHALL appear with stu__mgr__valid=1 at cycle N+1.
REQ-025 With mgr__stu__ready held at 1 and the source continuously valid, throughput SHALL be one word per cycle.
REQ-026 The framer FSM SHALL have states IDLE (next word starts a packet) and IN_PKT.
REQ-027 In IDLE, a loaded word SHALL be emitted with cntl SOM_EOM if last=1, else with SOM and the FSM SHALL enter IN_PKT.
REQ-028 In IN_PKT, a word SHALL be emitted with cntl EOM and the FSM SHALL return to IDLE if last=1, else with MOM.
REQ-029 The FSM SHALL advance when a word is loaded into the output stage, not on upstream acceptance.
REQ-030 oob_data SHALL be captured from the SOM/SOM_EOM word and driven on every word of that packet; later source oob values SHALL be ignored.
REQ-031 A word counter (width clog2(MAX_PKT)+1) SHALL count words of the current packet.
REQ-032 When the MAX_PKT-th word of a packet has last=0, that word SHALL be emitted as EOM, the FSM SHALL return to IDLE, and stu__sys__pkt_err SHALL set.
REQ-033 After a truncation, the next word SHALL start a new packet.
REQ-034 stu__sys__pkt_err SHALL clear only on reset.

Reset
REQ-035 On reset_poweron=1 at a clock edge, the block SHALL produce: stu__mgr__valid=0, stu__mgr__cntl=00, type/data/oob=0, FIFO empty, stu__src__ready=1 from the next cycle, FSM=IDLE, counter=0, pkt_err=0, idle=1.
REQ-036 Reset mid-packet SHALL discard all buffered and pending words with no EOM emitted.

Structure
REQ-037 A shared package SHALL hold the cntl encodings, the FSM state enum and the default widths; the manager side SHALL use the same package.
REQ-038 The FIFO SHALL be a single sub-module, stack_up_tx_fifo (parameterised width/depth, registered count); framer and output stage SHALL be in stack_up_tx.

Verification
REQ-039 Scenario: 1-word packet, data=0xA5, oob=0x11, last=1, ready=1 -> valid at N+1 with cntl=00, data=0xA5, oob=0x11; idle=1 at N+2.
REQ-040 Scenario: 4-word packet, oob values 7,9,9,9 -> cntl 01,10,10,11 with oob=7 on all four words.
REQ-041 Scenario: ready=0 for 20 cycles while pushing 10 words -> stu__src__ready drops after 8 accepted plus 1 held in the output stage; outputs stable throughout; after ready=1, all 9 words delivered in order, then the 10th.
REQ-042 Scenario: MAX_PKT=4, 6-word packet with no last until word 6 -> cntl 01,10,10,11,01,11; pkt_err=1 after word 4.
REQ-043 Scenario: reset asserted after the 2nd word of a 5-word packet -> valid=0 next cycle; next packet starts with SOM; pkt_err=0.
REQ-044 Scenario: random valid/ready, 1000 packets -> scoreboard shows no loss, no duplication, correct framing.
